// File: rtl/fir_pkg.sv
// fir_pkg: shared sizes and state encoding for the FIR stimulus source
package fir_pkg;
    localparam int N        = 16;
    localparam int DEPTH    = 32;
    localparam int AW       = 5;
    localparam int PERIOD_W = 8;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sample_ram.sv
// sample_ram: waveform store, synchronous write, asynchronous read, no reset
module sample_ram #(
    parameter int N     = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [N-1:0]  wd,
    input  logic [AW-1:0] ra,
    output logic [N-1:0]  rd
);
    logic [N-1:0] mem [DEPTH];

    // write port; a write lands on the edge so same-cycle reads see old data
    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;

    assign rd = mem[ra];
endmodule

// File: rtl/sample_playback_source.sv
// sample_playback_source: plays a stored waveform period as a valid/ready stream
module sample_playback_source #(
    parameter int N     = fir_pkg::N,
    parameter int DEPTH = fir_pkg::DEPTH,
    parameter int AW    = fir_pkg::AW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [N-1:0]                wr_data,
    input  logic                        start,
    input  logic                        stop,
    input  logic [AW-1:0]               step,
    input  logic [fir_pkg::PERIOD_W-1:0] num_periods,
    output logic [N-1:0]                data_out,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic                        busy,
    output logic                        done
);
    import fir_pkg::*;

    state_t                state, state_nx;
    logic [AW-1:0]         rd_ptr, step_q, ld_ptr, ld_step, ptr_nx;
    logic [PERIOD_W-1:0]   period_cnt, np_q, ld_np, cnt_nx;
    logic [AW:0]           sum;
    logic [N-1:0]          rd_data;
    logic                  last, last_nx, wrap, xfer, idle, do_start, do_load, finish;

    sample_ram #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk (clk),
        .we  (wr_en & idle),
        .wa  (wr_addr),
        .wd  (wr_data),
        .ra  (ld_ptr),
        .rd  (rd_data)
    );

    // next-pointer arithmetic; in IDLE the load starts from address 0 with live step/period inputs
    always_comb begin
        idle     = state == IDLE;
        xfer     = data_valid & data_ready;
        do_start = idle & start & !stop;
        finish   = !idle & !stop & xfer & last;
        do_load  = do_start | (!idle & !stop & xfer & !last);
        ld_ptr   = idle ? '0 : rd_ptr;
        ld_step  = idle ? step : step_q;
        ld_np    = idle ? num_periods : np_q;
        sum      = {1'b0, ld_ptr} + {1'b0, (ld_step == '0) ? AW'(1) : ld_step};
        wrap     = sum >= (AW+1)'(DEPTH);
        ptr_nx   = wrap ? AW'(sum - (AW+1)'(DEPTH)) : sum[AW-1:0];
        cnt_nx   = (idle ? '0 : period_cnt) + PERIOD_W'(wrap);
        last_nx  = (ld_np != '0) && wrap && (cnt_nx == ld_np);
    end

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    // next state: stop or the final accepted sample returns to IDLE
    always_comb
        state_nx = idle ? (do_start ? RUN : IDLE) : ((stop | (xfer & last)) ? IDLE : RUN);

    // state-derived outputs
    always_comb
        busy = state != IDLE;

    // playback datapath: output register, pointer, period counter and done pulse
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            rd_ptr     <= '0;
            period_cnt <= '0;
            last       <= 1'b0;
            step_q     <= '0;
            np_q       <= '0;
        end else begin
            done <= finish;
            if (do_start) begin
                step_q <= step;
                np_q   <= num_periods;
            end
            if (do_load) begin
                data_out   <= rd_data;
                data_valid <= 1'b1;
                rd_ptr     <= ptr_nx;
                period_cnt <= cnt_nx;
                last       <= last_nx;
            end else if (!idle && (stop || (xfer && last))) begin
                data_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_sample_playback_source.sv
// tb_sample_playback_source: scoreboard bench for the waveform playback source
module tb_sample_playback_source;
    logic        clk = 0;
    logic        reset = 0;
    logic        wr_en = 0;
    logic [4:0]  wr_addr = 0;
    logic [15:0] wr_data = 0;
    logic        start = 0;
    logic        stop = 0;
    logic [4:0]  step = 0;
    logic [7:0]  num_periods = 0;
    logic [15:0] data_out;
    logic        data_valid;
    logic        data_ready = 1;
    logic        busy;
    logic        done;

    int errs = 0;
    int checks = 0;
    int n_acc = 0;
    int done_cnt = 0;
    int exp_done_at = 0;
    logic [15:0] m [32];
    logic [15:0] q [$];

    sample_playback_source dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .step(step), .num_periods(num_periods),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // scoreboard consumer: every accepted sample is compared against the queue head
    always @(negedge clk) begin
        if (reset && data_valid && data_ready) begin
            chk("sb_has_entry", q.size() != 0, 1);
            if (q.size() != 0) chk("sample", data_out, q.pop_front());
            n_acc++;
        end
        if (reset && done) begin
            done_cnt++;
            chk("done_at", n_acc, exp_done_at);
            chk("busy_at_done", busy, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_en = 1; wr_addr = 5'(a); wr_data = d;
        tick();
        wr_en = 0;
        m[a] = d;
    endtask

    // reference sequence: walk addresses by the effective step, count wraps as periods
    task automatic push_seq(input int s, input int np, input int maxn);
        int ptr = 0, cnt = 0, n = 0, se;
        se = (s == 0) ? 1 : s;
        while (n < maxn) begin
            q.push_back(m[ptr]);
            n++;
            ptr += se;
            if (ptr >= 32) begin
                ptr -= 32;
                cnt++;
                if (np != 0 && cnt == np) break;
            end
        end
        exp_done_at = n_acc + n;
    endtask

    task automatic go(input int s, input int np);
        step = 5'(s); num_periods = 8'(np); start = 1;
        tick();
        start = 0;
        chk("first_valid", data_valid, 1);
        chk("busy_run", busy, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        chk("idle_reached", busy, 0);
        tick();
        chk("done_low", done, 0);
        chk("valid_idle", data_valid, 0);
        chk("sb_drained", q.size(), 0);
    endtask

    initial begin
        int d0;
        #2;
        chk("rst_data", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #10 reset = 1;
        tick();
        for (int i = 0; i < 32; i++) wr(i, 16'(i * 64));

        // 1: full period, step 1
        d0 = done_cnt;
        push_seq(1, 1, 1000);
        go(1, 1);
        chk("first_sample", data_out, 0);
        wait_idle(200);
        chk("done_t1", done_cnt - d0, 1);

        // 2: step 3, two periods
        d0 = done_cnt;
        push_seq(3, 2, 1000);
        chk("t2_len", q.size(), 22);
        go(3, 2);
        wait_idle(200);
        chk("done_t2", done_cnt - d0, 1);

        // 3: backpressure holds the sample
        d0 = done_cnt;
        push_seq(1, 1, 1000);
        go(1, 1);
        for (int i = 0; i < 50 && data_out != 320; i++) tick();
        chk("bp_reach", data_out, 320);
        data_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", data_out, 320);
            chk("bp_valid", data_valid, 1);
        end
        data_ready = 1;
        tick();
        chk("bp_next", data_out, 384);
        wait_idle(200);
        chk("done_t3", done_cnt - d0, 1);

        // 4: continuous mode, then stop
        d0 = done_cnt;
        push_seq(1, 0, 200);
        go(1, 0);
        for (int i = 0; i < 300 && n_acc < exp_done_at - 200 + 105; i++) tick();
        chk("cont_running", data_valid, 1);
        stop = 1;
        tick();
        stop = 0;
        chk("stop_valid", data_valid, 0);
        chk("stop_busy", busy, 0);
        tick();
        chk("done_t4", done_cnt - d0, 0);
        q.delete();

        // 5: asynchronous reset mid-run, then replay
        d0 = done_cnt;
        push_seq(1, 0, 200);
        go(1, 0);
        repeat (10) tick();
        #2 reset = 0;
        #1;
        chk("arst_valid", data_valid, 0);
        chk("arst_busy", busy, 0);
        q.delete();
        repeat (2) tick();
        reset = 1;
        tick();
        chk("done_t5", done_cnt - d0, 0);
        d0 = done_cnt;
        push_seq(1, 1, 1000);
        go(1, 1);
        chk("replay_first", data_out, 0);
        wait_idle(200);
        chk("done_t5b", done_cnt - d0, 1);

        // 6: step 0, writes and start ignored while running
        d0 = done_cnt;
        push_seq(0, 1, 1000);
        go(0, 1);
        wr_en = 1; wr_addr = 10; wr_data = 16'hFFFF; start = 1;
        tick();
        tick();
        wr_en = 0; start = 0;
        wait_idle(200);
        chk("done_t6", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
